// File: rtl/iod_delay_line_ctrl.sv
// Tap sequencer for one IOD dynamic delay line: turns absolute tap / reload
// requests into spaced DELAY_LINE_LOAD / MOVE pulses and tracks the current tap.
//
// state  | meaning
// INIT   | post-reset auto-load; LOAD pulse held for one cycle
// IDLE   | ready for a request
// LOAD   | DELAY_LINE_LOAD pulse cycle
// STEP   | DELAY_LINE_MOVE pulse cycle
// SETTLE | pulse-free settle window, decides next action on its last cycle
// FIN    | DONE pulse cycle
module iod_delay_line_ctrl #(
   parameter int TAP_W         = 8,
   parameter int LOAD_VAL      = 1,
   parameter int MAX_TAP       = 255,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             FAB_CLK,
   input  logic             RESET_N,
   input  logic             REQ_VALID,
   input  logic             REQ_LOAD,
   input  logic [TAP_W-1:0] REQ_TAP,
   output logic             REQ_READY,
   output logic             DONE,
   output logic             ERR,
   output logic             BUSY,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TAP_W-1:0] LOAD_TAP    = TAP_W'(LOAD_VAL);
   localparam logic [TAP_W:0]   MAX_TAP_X   = (TAP_W+1)'(MAX_TAP);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_SETTLE,
      S_FIN
   } state_t;

   state_t             state_q, state_n;
   logic [TAP_W-1:0]   tgt_q, tgt_n;
   logic [TAP_W-1:0]   tap_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               last_load_q, last_load_n;
   logic               boot_q, boot_n;
   logic               dir_n, err_n;
   logic               load_n, move_n;

   always_comb begin
      state_n     = state_q;
      tgt_n       = tgt_q;
      tap_n       = CUR_TAP;
      cnt_n       = cnt_q;
      last_load_n = last_load_q;
      boot_n      = boot_q;
      dir_n       = DELAY_LINE_DIRECTION;
      err_n       = ERR;

      case (state_q)
         S_INIT: begin
            // the registered LOAD output marks the second INIT cycle
            tap_n = LOAD_TAP;
            if (DELAY_LINE_LOAD) begin
               state_n     = S_SETTLE;
               cnt_n       = SETTLE_LAST;
               last_load_n = 1'b1;
            end
         end
         S_IDLE: begin
            if (REQ_VALID && REQ_READY) begin
               err_n = 1'b0;
               if (REQ_LOAD) begin
                  state_n = S_LOAD;
               end else if ({1'b0, REQ_TAP} > MAX_TAP_X) begin
                  err_n   = 1'b1;
                  state_n = S_FIN;
               end else if (REQ_TAP == CUR_TAP) begin
                  state_n = S_FIN;
               end else begin
                  tgt_n   = REQ_TAP;
                  dir_n   = (REQ_TAP > CUR_TAP);
                  state_n = S_STEP;
               end
            end
         end
         S_LOAD: begin
            tap_n       = LOAD_TAP;
            last_load_n = 1'b1;
            cnt_n       = SETTLE_LAST;
            state_n     = S_SETTLE;
         end
         S_STEP: begin
            tap_n       = DELAY_LINE_DIRECTION ? CUR_TAP + TAP_W'(1) : CUR_TAP - TAP_W'(1);
            last_load_n = 1'b0;
            cnt_n       = SETTLE_LAST;
            state_n     = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_n = cnt_q - CNT_W'(1);
            end else begin
               boot_n = 1'b0;
               if (DELAY_LINE_OUT_OF_RANGE) begin
                  err_n = 1'b1;
                  if (!last_load_q)
                     tap_n = DELAY_LINE_DIRECTION ? CUR_TAP - TAP_W'(1) : CUR_TAP + TAP_W'(1);
                  state_n = boot_q ? S_IDLE : S_FIN;
               end else if (last_load_q || (CUR_TAP == tgt_q)) begin
                  state_n = boot_q ? S_IDLE : S_FIN;
               end else begin
                  state_n = S_STEP;
               end
            end
         end
         S_FIN: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_INIT;
         end
      endcase

      load_n = (state_n == S_LOAD) || ((state_q == S_INIT) && (state_n == S_INIT));
      move_n = (state_n == S_STEP);
   end

   always_ff @(posedge FAB_CLK) begin
      if (!RESET_N) begin
         state_q              <= S_INIT;
         tgt_q                <= LOAD_TAP;
         cnt_q                <= '0;
         last_load_q          <= 1'b1;
         boot_q               <= 1'b1;
         CUR_TAP              <= LOAD_TAP;
         REQ_READY            <= 1'b0;
         DONE                 <= 1'b0;
         ERR                  <= 1'b0;
         BUSY                 <= 1'b1;
         DELAY_LINE_LOAD      <= 1'b0;
         DELAY_LINE_MOVE      <= 1'b0;
         DELAY_LINE_DIRECTION <= 1'b0;
      end else begin
         state_q              <= state_n;
         tgt_q                <= tgt_n;
         cnt_q                <= cnt_n;
         last_load_q          <= last_load_n;
         boot_q               <= boot_n;
         CUR_TAP              <= tap_n;
         REQ_READY            <= (state_n == S_IDLE);
         DONE                 <= (state_n == S_FIN);
         ERR                  <= err_n;
         BUSY                 <= (state_n != S_IDLE);
         DELAY_LINE_LOAD      <= load_n;
         DELAY_LINE_MOVE      <= move_n;
         DELAY_LINE_DIRECTION <= dir_n;
      end
   end

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Directed bench for iod_delay_line_ctrl: reset/auto-load, up/down moves, no-op,
// illegal target, reload, out-of-range undo and reset mid-move.
module tb_iod_delay_line_ctrl;

   logic       FAB_CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       REQ_VALID = 1'b0;
   logic       REQ_LOAD = 1'b0;
   logic [7:0] REQ_TAP = 8'd0;
   logic       REQ_READY, DONE, ERR, BUSY;
   logic [7:0] CUR_TAP;
   logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
   logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;

   iod_delay_line_ctrl #(
      .TAP_W(8), .LOAD_VAL(1), .MAX_TAP(100), .SETTLE_CYCLES(4)
   ) dut (
      .FAB_CLK(FAB_CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_LOAD(REQ_LOAD), .REQ_TAP(REQ_TAP),
      .REQ_READY(REQ_READY), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .CUR_TAP(CUR_TAP),
      .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int cyc = 0;
   always @(posedge FAB_CLK) cyc <= cyc + 1;

   int move_cnt = 0, load_cnt = 0, done_cnt = 0, overlap = 0;
   int last_pulse = -1, min_gap = 1000;
   always @(negedge FAB_CLK) begin
      if (DELAY_LINE_MOVE) move_cnt++;
      if (DELAY_LINE_LOAD) load_cnt++;
      if (DONE) done_cnt++;
      if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) overlap++;
      if (DELAY_LINE_LOAD || DELAY_LINE_MOVE) begin
         if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // delay = edges from acceptance to the cycle DONE is seen high (-1 on timeout)
   task automatic do_req(input logic ld, input int tap, input int oor_at,
                         output int delay, output int err_acc, output int moves, output int loads);
      int m0, l0, t, seen;
      @(negedge FAB_CLK);
      REQ_VALID = 1'b1;
      REQ_LOAD  = ld;
      REQ_TAP   = 8'(tap);
      for (int i = 0; i < 100 && !REQ_READY; i++) @(negedge FAB_CLK);
      @(posedge FAB_CLK);
      #1;
      t = cyc; m0 = move_cnt; l0 = load_cnt; err_acc = int'(ERR);
      REQ_VALID = 1'b0;
      delay = -1;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge FAB_CLK);
         if (oor_at > 0 && DELAY_LINE_MOVE) begin
            seen++;
            if (seen == oor_at) DELAY_LINE_OUT_OF_RANGE = 1'b1;
         end
         if (DONE) begin
            delay = cyc - t;
            break;
         end
      end
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      moves = move_cnt - m0;
      loads = load_cnt - l0;
   endtask

   initial begin
      int d, ea, mv, ld, e1, rc, d0;
      repeat (3) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      chk("rst_ready", int'(REQ_READY), 0);
      chk("rst_done",  int'(DONE), 0);
      chk("rst_err",   int'(ERR), 0);
      chk("rst_busy",  int'(BUSY), 1);
      chk("rst_tap",   int'(CUR_TAP), 1);
      chk("rst_load",  int'(DELAY_LINE_LOAD), 0);
      chk("rst_move",  int'(DELAY_LINE_MOVE), 0);
      chk("rst_dir",   int'(DELAY_LINE_DIRECTION), 0);

      // reset release: auto-load then ready 5 cycles later, no DONE
      d0 = done_cnt;
      RESET_N = 1'b1;
      @(posedge FAB_CLK);
      #1 e1 = cyc;
      @(negedge FAB_CLK);
      chk("init_load_hi", int'(DELAY_LINE_LOAD), 1);
      @(negedge FAB_CLK);
      chk("init_load_lo", int'(DELAY_LINE_LOAD), 0);
      rc = -1;
      for (int i = 0; i < 50; i++) begin
         if (REQ_READY) begin rc = cyc; break; end
         @(negedge FAB_CLK);
      end
      chk("init_ready_lat", rc - e1, 5);
      chk("init_tap", int'(CUR_TAP), 1);
      chk("init_no_done", done_cnt - d0, 0);

      // 1 -> 4
      do_req(1'b0, 4, 0, d, ea, mv, ld);
      chk("up_lat", d, 15);
      chk("up_moves", mv, 3);
      chk("up_dir", int'(DELAY_LINE_DIRECTION), 1);
      chk("up_tap", int'(CUR_TAP), 4);
      chk("up_err", int'(ERR), 0);

      // 4 -> 2
      do_req(1'b0, 2, 0, d, ea, mv, ld);
      chk("dn_lat", d, 10);
      chk("dn_moves", mv, 2);
      chk("dn_dir", int'(DELAY_LINE_DIRECTION), 0);
      chk("dn_tap", int'(CUR_TAP), 2);

      // 2 -> 2
      do_req(1'b0, 2, 0, d, ea, mv, ld);
      chk("same_lat", d, 0);
      chk("same_pulses", mv + ld, 0);
      chk("same_tap", int'(CUR_TAP), 2);

      // illegal target
      do_req(1'b0, 200, 0, d, ea, mv, ld);
      chk("ill_lat", d, 0);
      chk("ill_err", int'(ERR), 1);
      chk("ill_pulses", mv + ld, 0);
      chk("ill_tap", int'(CUR_TAP), 2);

      // legal request clears ERR at acceptance
      do_req(1'b0, 3, 0, d, ea, mv, ld);
      chk("clr_err_acc", ea, 0);
      chk("clr_lat", d, 5);
      chk("clr_tap", int'(CUR_TAP), 3);

      // reload
      do_req(1'b1, 77, 0, d, ea, mv, ld);
      chk("ld_lat", d, 5);
      chk("ld_loads", ld, 1);
      chk("ld_moves", mv, 0);
      chk("ld_tap", int'(CUR_TAP), 1);

      // 1 -> 5 with out-of-range flagged during the second step
      do_req(1'b0, 5, 2, d, ea, mv, ld);
      chk("oor_lat", d, 10);
      chk("oor_moves", mv, 2);
      chk("oor_err", int'(ERR), 1);
      chk("oor_tap", int'(CUR_TAP), 2);

      chk("pulse_gap", min_gap, 5);
      chk("load_move_overlap", overlap, 0);

      // reset in the middle of a move
      @(negedge FAB_CLK);
      REQ_VALID = 1'b1; REQ_LOAD = 1'b0; REQ_TAP = 8'd6;
      @(posedge FAB_CLK);
      #1 REQ_VALID = 1'b0;
      rc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge FAB_CLK);
         if (DELAY_LINE_MOVE) begin rc = 1; break; end
      end
      chk("mid_move_seen", rc, 1);
      RESET_N = 1'b0;
      @(posedge FAB_CLK);
      #1;
      chk("mid_rst_move", int'(DELAY_LINE_MOVE), 0);
      chk("mid_rst_busy", int'(BUSY), 1);
      chk("mid_rst_tap", int'(CUR_TAP), 1);
      @(negedge FAB_CLK);
      RESET_N = 1'b1;
      @(posedge FAB_CLK);
      #1 d0 = done_cnt;
      @(negedge FAB_CLK);
      chk("mid_autoload", int'(DELAY_LINE_LOAD), 1);
      rc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge FAB_CLK);
         if (REQ_READY) begin rc = 1; break; end
      end
      chk("mid_ready", rc, 1);
      chk("mid_tap", int'(CUR_TAP), 1);
      chk("mid_no_done", done_cnt - d0, 0);
      chk("mid_err", int'(ERR), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/iod_delay_line_ctrl.md
Name: iod_delay_line_ctrl

Overview:
Sequencer for the dynamic delay line of one PolarFire IOD lane in the DDR3 PHY, such as the CS_N output lane. It accepts absolute tap-target or reload requests from fabric training logic over a valid/ready handshake. It converts each request into correctly spaced DELAY_LINE_LOAD, DELAY_LINE_MOVE and DELAY_LINE_DIRECTION pulses, tracks the current tap and flags out-of-range. It sits in the FAB_CLK domain between the training FSM and the IOD delay-line control pins.

Parameters:
TAP_W, 8, width of tap count and request target
LOAD_VAL, 1, tap value the delay line holds after a LOAD; matches the IOD TX_DELAY_VAL
MAX_TAP, 255, highest legal tap target
SETTLE_CYCLES, 4, idle FAB_CLK cycles after every LOAD/MOVE pulse before the next action (minimum 1)

Ports:
FAB_CLK  input  1  fabric clock; all logic is on the rising edge
RESET_N  input  1  reset, synchronous, active-low
REQ_VALID  input  1  request valid
REQ_LOAD  input  1  1 = reload the delay line to LOAD_VAL; REQ_TAP is ignored
REQ_TAP  input  TAP_W  absolute target tap
REQ_READY  output  1  controller can accept a request
DONE  output  1  one-cycle pulse when a request completes
ERR  output  1  sticky error for the last request
BUSY  output  1  high whenever the FSM is not in IDLE
CUR_TAP  output  TAP_W  tracked current tap
DELAY_LINE_LOAD  output  1  to IOD DELAY_LINE_LOAD
DELAY_LINE_MOVE  output  1  to IOD DELAY_LINE_MOVE
DELAY_LINE_DIRECTION  output  1  to IOD DELAY_LINE_DIRECTION; 1 = increment
DELAY_LINE_OUT_OF_RANGE  input  1  from IOD

Behaviour:
- Clock and reset: one clock, FAB_CLK. Reset RESET_N is synchronous and active-low.
- Reset values (RESET_N low at an edge): REQ_READY=0, DONE=0, ERR=0, BUSY=1, CUR_TAP=LOAD_VAL, all DELAY_LINE_* outputs=0, state=INIT.
- All outputs are registered.
- FSM states: INIT, IDLE, LOAD, STEP, SETTLE, FIN.
- INIT: first cycle after reset release.
  - DELAY_LINE_LOAD=1 for one cycle, CUR_TAP<=LOAD_VAL.
  - Then SETTLE. Settle exit goes to IDLE with no DONE pulse.
- IDLE: REQ_READY=1, BUSY=0. Acceptance happens when REQ_VALID && REQ_READY at edge T. ERR is cleared at T, then:
  - REQ_LOAD=1 -> LOAD.
  - REQ_TAP>MAX_TAP -> ERR<=1, go to FIN. No pulses are issued.
  - REQ_TAP==CUR_TAP -> FIN.
  - Otherwise latch the target. Set DIRECTION<=(REQ_TAP>CUR_TAP), then go to STEP.
- DIRECTION is stable from T+1 until the request completes.
- LOAD: DELAY_LINE_LOAD=1 for exactly one cycle, CUR_TAP<=LOAD_VAL, then SETTLE.
- STEP: DELAY_LINE_MOVE=1 for exactly one cycle. CUR_TAP moves ±1 per DIRECTION, then SETTLE.
- SETTLE: count SETTLE_CYCLES cycles with no pulses. In the last settle cycle:
  - If DELAY_LINE_OUT_OF_RANGE=1: ERR<=1, undo the last CUR_TAP change (a LOAD is not undone), go to FIN.
  - Else if CUR_TAP==target, or the last action was LOAD: go to FIN.
  - Else go to STEP.
- FIN: DONE=1 for one cycle, then IDLE. REQ_READY is 0 in FIN.
- Latency for accept at edge T and k = |target−CUR_TAP| taps, with S = SETTLE_CYCLES:
  - Tap request: DONE is high in cycle T+1+k·(1+S).
  - LOAD request: DONE is high in cycle T+2+S.
  - Illegal-target or k=0 request: DONE is high in cycle T+1.
- DELAY_LINE_LOAD and DELAY_LINE_MOVE are never high in the same cycle. Consecutive pulses are ≥S+1 cycles apart.
- REQ_VALID outside IDLE is ignored. The requester holds its request until REQ_READY.
- CUR_TAP arithmetic is unsigned TAP_W bits. It never wraps, because targets are bounded by MAX_TAP.
- Reset mid-operation: pulses drop at the reset edge. After release the INIT auto-load repeats and any pending request is lost.

Test Plan:
- Reset release with S=4, LOAD_VAL=1 -> DELAY_LINE_LOAD high 1 cycle at the first post-reset edge; REQ_READY rises 5 cycles later; CUR_TAP=1; no DONE pulse.
- Request tap 4 from tap 1 -> DIRECTION=1, 3 MOVE pulses each 5 cycles apart, DONE at T+16, CUR_TAP=4, ERR=0.
- Request tap 2 from tap 4 -> DIRECTION=0, 2 MOVE pulses, DONE at T+11, CUR_TAP=2.
- Request tap 2 while CUR_TAP=2 -> DONE at T+1; no pulses.
- With MAX_TAP=100, request tap 200 -> DONE at T+1, ERR=1, no pulses. A following legal request clears ERR at acceptance.
- Drive OUT_OF_RANGE=1 during the second step of a 1→5 move -> ERR=1, CUR_TAP=2, DONE asserted. Also assert RESET_N low mid-move -> MOVE low at the reset edge, auto-load after release.
